solver_job_issuer: RTL and testbench
====================================

// Module: solver_job_issuer
// PURPOSE
//  Initiator/host side of the Solver command interface. Accepts jobs (encrypt, decrypt,
//  password-gen) on a valid/ready request port, drives the Solver data buses and work
//  code, waits the Solver latency, captures the result and returns it on a valid/ready
//  response port. One job in flight; sits between the system job source and Solver.
// PARAMETERS
//  SOLVER_LAT  4   cycles from work code/data applied to Solver output valid (>=1)
//  CNT_W       16  width of completed-job counter
// PORTS
//  Clk          in   1      system clock, all logic on posedge
//  Reset        in   1      synchronous, active-high reset
//  req_valid    in   1      job request valid
//  req_ready    out  1      issuer can accept a job
//  req_op       in   2      00 encrypt, 01 decrypt, 10 password gen, 11 illegal
//  req_data     in   78     op00: plaintext in [59:0]; op01: ciphertext [77:0]; op10: ignored
//  rsp_valid    out  1      response valid
//  rsp_ready    in   1      response consumer ready
//  rsp_op       out  2      op of the job being returned
//  rsp_data     out  78     op00: ciphertext; op01/10: {18'b0, 60-bit result}; err: 0
//  rsp_err      out  1      1 = illegal op, no Solver access made
//  jobs_done    out  CNT_W  count of responses handed off (rsp_valid&rsp_ready), wraps
//  data_1_80    out  60     to Solver plaintext input
//  data_2_96    out  78     to Solver ciphertext input
//  work_2       out  2      to Solver work code; 2'b11 = hold (Solver keeps outputs)
//  output_1_96  in   78     from Solver encrypt result
//  output_2_80  in   60     from Solver decrypt/password result
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 after reset; rsp_valid=0, rsp_err=0, rsp_op=0,
//   rsp_data=0, jobs_done=0, data_1_80=0, data_2_96=0, work_2=2'b11, lat counter=0.
//  FSM IDLE -> WAIT -> RESP -> IDLE (illegal op: IDLE -> RESP directly).
//  IDLE: req_ready=1. On req_valid&req_ready latch op/data.
//   op 00/01/10: next cycle work_2=op, data_1_80=req_data[59:0], data_2_96=req_data,
//   counter loaded SOLVER_LAT-1, go WAIT. op 11: rsp_err=1, rsp_data=0, go RESP.
//  WAIT: req_ready=0; work_2 and data buses held stable; counter decrements each cycle.
//   On counter==0: capture rsp_data (op00: output_1_96; else {18'b0,output_2_80}),
//   rsp_op=op, rsp_err=0, work_2<=2'b11, go RESP.
//  RESP: rsp_valid=1; rsp_op/rsp_data/rsp_err stable until rsp_valid&rsp_ready;
//   on handshake jobs_done+=1 (wraps 2^CNT_W-1 -> 0), rsp_valid<=0, go IDLE.
//  Latency: accept at cycle T -> work_2 valid T+1 .. T+SOLVER_LAT -> rsp_valid at
//   T+SOLVER_LAT+1 (rsp_ready held high). Illegal op: rsp_valid at T+1.
//  req_ready=0 in WAIT and RESP; no new accept until response handed off (no bypass,
//   accept earliest the cycle after handshake).
//  work_2 is 2'b11 whenever not in WAIT, so Solver outputs never change outside a job.
//  Reset mid-operation: job dropped, no response, all outputs to reset values next edge.
// TESTING (bench uses Solver stub with SOLVER_LAT=4; output_1_96={18'h2AAAA,data_1_80},
//  output_2_80=data_2_96[59:0]^60'hFFF, password output=60'h0BADC0FFEE12345)
//  op00, req_data[59:0]=60'h123456789ABCDEF -> rsp at T+5, rsp_data={18'h2AAAA,60'h123456789ABCDEF}
//  op01, req_data=78'h3_0000_0000_0000_0ABC -> rsp_data=78'h0_0000_0000_0000_0543, err=0
//  op10 -> rsp_data={18'b0,60'h0BADC0FFEE12345}; op11 -> rsp at T+1, err=1, data=0, work_2 stays 11
//  rsp_ready low 10 cycles in RESP -> rsp fields stable, req_ready=0, jobs_done unchanged
//  Reset asserted during WAIT cycle 2 -> no rsp_valid, work_2=11, req_ready=1 after reset
//  CNT_W=4, 17 back-to-back jobs -> jobs_done wraps to 1; req_valid during WAIT ignored

Source files
------------

// File: rtl/solver_job_issuer.sv
// ----------------------------------------------------------------------------
// solver_job_issuer
//   Host-side issuer for the Solver command interface. Takes one job at a
//   time (encrypt / decrypt / password-gen) from a valid/ready request port,
//   drives the Solver data buses and work code for SOLVER_LAT cycles,
//   captures the Solver result and returns it on a valid/ready response port.
//   Illegal ops (2'b11) are answered directly with an error response and
//   never touch the Solver.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   req_valid/req_ready   job request handshake
//   req_op, req_data      job op code and operand
//   rsp_valid/rsp_ready   response handshake
//   rsp_op, rsp_data      op and result of the returned job
//   rsp_err               illegal op response (rsp_data is zero)
//   jobs_done             wrapping count of handed-off responses
//   data_1_80, data_2_96  Solver plaintext / ciphertext inputs
//   work_2                Solver work code, 2'b11 = hold
//   output_1_96           Solver encrypt result
//   output_2_80           Solver decrypt / password result
// ----------------------------------------------------------------------------
module solver_job_issuer #(
   parameter int unsigned SOLVER_LAT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [77:0]      req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_op,
   output logic [77:0]      rsp_data,
   output logic             rsp_err,
   output logic [CNT_W-1:0] jobs_done,
   output logic [59:0]      data_1_80,
   output logic [77:0]      data_2_96,
   output logic [1:0]       work_2,
   input  logic [77:0]      output_1_96,
   input  logic [59:0]      output_2_80
);

   localparam int unsigned LAT_W = (SOLVER_LAT > 1) ? $clog2(SOLVER_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [LAT_W-1:0] lat_cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_op    <= '0;
         rsp_data  <= '0;
         jobs_done <= '0;
         data_1_80 <= '0;
         data_2_96 <= '0;
         work_2    <= 2'b11;
         lat_cnt   <= '0;
         op_q      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_q      <= req_op;
                  req_ready <= 1'b0;
                  if (req_op == 2'b11) begin
                     // Illegal op bypasses the Solver entirely.
                     rsp_op    <= req_op;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     work_2    <= req_op;
                     data_1_80 <= req_data[59:0];
                     data_2_96 <= req_data;
                     lat_cnt   <= LAT_W'(SOLVER_LAT - 1);
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  rsp_data  <= (op_q == 2'b00) ? output_1_96 : {18'b0, output_2_80};
                  rsp_op    <= op_q;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  // Return to hold so the Solver outputs freeze between jobs.
                  work_2    <= 2'b11;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  jobs_done <= jobs_done + CNT_W'(1);
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_solver_job_issuer.sv
module tb_solver_job_issuer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [77:0] req_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_op;
   logic [77:0] rsp_data;
   logic        rsp_err;
   logic [3:0]  jobs_done;
   logic [59:0] data_1_80;
   logic [77:0] data_2_96;
   logic [1:0]  work_2;
   logic [77:0] output_1_96;
   logic [59:0] output_2_80;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   logic [3:0]  exp_cnt    = '0;

   typedef struct {
      logic [1:0]  op;
      logic [77:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];

   always #5 Clk = ~Clk;

   solver_job_issuer #(.SOLVER_LAT(4), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .jobs_done(jobs_done),
      .data_1_80(data_1_80), .data_2_96(data_2_96), .work_2(work_2),
      .output_1_96(output_1_96), .output_2_80(output_2_80)
   );

   // Solver stub: recomputes while a work code is applied, holds on 2'b11.
   always @(posedge Clk) begin
      if (work_2 != 2'b11) begin
         output_1_96 <= {18'h2AAAA, data_1_80};
         output_2_80 <= (work_2 == 2'b10) ? 60'h0BADC0FFEE12345 : (data_2_96[59:0] ^ 60'hFFF);
      end
   end

   function automatic exp_t model(input logic [1:0] op, input logic [77:0] d);
      exp_t e;
      e.op  = op;
      e.err = 1'b0;
      case (op)
         2'b00:   e.data = {18'h2AAAA, d[59:0]};
         2'b01:   e.data = {18'b0, d[59:0] ^ 60'hFFF};
         2'b10:   e.data = {18'b0, 60'h0BADC0FFEE12345};
         default: begin e.data = '0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   // Presents one request, waits (bounded) for acceptance, pushes the expectation.
   task automatic send_req(input logic [1:0] op, input logic [77:0] d);
      int unsigned n = 0;
      @(negedge Clk);
      while (!req_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      vectors++;
      if (!req_ready) begin
         miscompares++;
         $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      end
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      sb.push_back(model(op, d));
      @(posedge Clk);
      #1 req_valid = 1'b0;
   endtask

   // Cycles after the accept edge until rsp_valid is seen; 0 on timeout.
   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge Clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      exp_cnt = '0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge Clk);
      vectors++;
      if ({req_ready, rsp_valid, rsp_err, rsp_op, rsp_data, jobs_done, data_1_80, data_2_96, work_2}
          !== {1'b1, 1'b0, 1'b0, 2'b00, 78'h0, 4'h0, 60'h0, 78'h0, 2'b11}) begin
         miscompares++;
         $display("FAIL reset_state: ready=%b valid=%b err=%b op=%b data=%h cnt=%h d1=%h d2=%h work=%b required ready=1 valid=0 err=0 op=0 data=0 cnt=0 d1=0 d2=0 work=11",
                  req_ready, rsp_valid, rsp_err, rsp_op, rsp_data, jobs_done, data_1_80, data_2_96, work_2);
      end
   endtask

   task automatic test_encrypt();
      exp_t e;
      send_req(2'b00, {18'h3FFFF, 60'h123456789ABCDEF});
      for (int k = 1; k <= 5; k++) begin
         @(negedge Clk);
         vectors++;
         if (work_2 !== ((k <= 4) ? 2'b00 : 2'b11) || rsp_valid !== (k == 5) || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL enc_timing cycle T+%0d: work=%b valid=%b ready=%b required work=%b valid=%b ready=0",
                     k, work_2, rsp_valid, req_ready, (k <= 4) ? 2'b00 : 2'b11, k == 5);
         end
      end
      vectors++;
      if (data_1_80 !== 60'h123456789ABCDEF || data_2_96 !== {18'h3FFFF, 60'h123456789ABCDEF}) begin
         miscompares++;
         $display("FAIL enc_buses: d1=%h d2=%h", data_1_80, data_2_96);
      end
      e = sb.pop_front();
      vectors++;
      if (rsp_op !== e.op || rsp_data !== e.data || rsp_err !== e.err) begin
         miscompares++;
         $display("FAIL enc_rsp: op=%b data=%h err=%b required op=%b data=%h err=%b",
                  rsp_op, rsp_data, rsp_err, e.op, e.data, e.err);
      end
      @(negedge Clk);
      exp_cnt++;
      vectors++;
      if (rsp_valid !== 1'b0 || jobs_done !== exp_cnt || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL enc_handoff: valid=%b cnt=%0d ready=%b required valid=0 cnt=%0d ready=1",
                  rsp_valid, jobs_done, req_ready, exp_cnt);
      end
   endtask

   task automatic test_decrypt_pwgen();
      exp_t e;
      int   lat;
      logic [77:0] din [2];
      din[0] = 78'h3_0000_0000_0000_0ABC;
      din[1] = 78'h1234;
      for (int i = 0; i < 2; i++) begin
         send_req((i == 0) ? 2'b01 : 2'b10, din[i]);
         wait_rsp(lat);
         e = sb.pop_front();
         vectors++;
         if (lat != 5 || rsp_op !== e.op || rsp_data !== e.data || rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL op%b_rsp: lat=%0d op=%b data=%h err=%b required lat=5 op=%b data=%h err=%b",
                     e.op, lat, rsp_op, rsp_data, rsp_err, e.op, e.data, e.err);
         end
         @(negedge Clk);
         exp_cnt++;
         vectors++;
         if (jobs_done !== exp_cnt || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL op%b_cnt: cnt=%0d valid=%b required cnt=%0d valid=0", e.op, jobs_done, rsp_valid, exp_cnt);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t e;
      int   lat;
      send_req(2'b11, 78'h3FFF_FFFF_FFFF_FFFF_FFFF);
      wait_rsp(lat);
      e = sb.pop_front();
      vectors++;
      if (lat != 1 || rsp_op !== 2'b11 || rsp_data !== e.data || rsp_err !== 1'b1 || work_2 !== 2'b11) begin
         miscompares++;
         $display("FAIL illegal_rsp: lat=%0d op=%b data=%h err=%b work=%b required lat=1 op=11 data=0 err=1 work=11",
                  lat, rsp_op, rsp_data, rsp_err, work_2);
      end
      @(negedge Clk);
      exp_cnt++;
      vectors++;
      if (jobs_done !== exp_cnt || work_2 !== 2'b11) begin
         miscompares++;
         $display("FAIL illegal_cnt: cnt=%0d work=%b required cnt=%0d work=11", jobs_done, work_2, exp_cnt);
      end
   endtask

   task automatic test_stall();
      exp_t e;
      int   lat;
      rsp_ready = 1'b0;
      send_req(2'b01, 78'h2_1111_2222_3333_4444);
      wait_rsp(lat);
      e = sb.pop_front();
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_data !== e.data || rsp_err !== e.err ||
             req_ready !== 1'b0 || jobs_done !== exp_cnt) begin
            miscompares++;
            $display("FAIL stall_hold cycle %0d: valid=%b op=%b data=%h err=%b ready=%b cnt=%0d required valid=1 op=%b data=%h err=%b ready=0 cnt=%0d",
                     k, rsp_valid, rsp_op, rsp_data, rsp_err, req_ready, jobs_done, e.op, e.data, e.err, exp_cnt);
         end
         @(negedge Clk);
      end
      rsp_ready = 1'b1;
      @(negedge Clk);
      exp_cnt++;
      vectors++;
      if (rsp_valid !== 1'b0 || jobs_done !== exp_cnt) begin
         miscompares++;
         $display("FAIL stall_release: valid=%b cnt=%0d required valid=0 cnt=%0d", rsp_valid, jobs_done, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_wait();
      int seen = 0;
      send_req(2'b00, 78'h5555);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      void'(sb.pop_front());
      @(negedge Clk);
      vectors++;
      if (rsp_valid !== 1'b0 || work_2 !== 2'b11 || req_ready !== 1'b1 || jobs_done !== 4'h0 || data_1_80 !== 60'h0) begin
         miscompares++;
         $display("FAIL reset_mid_wait: valid=%b work=%b ready=%b cnt=%0d d1=%h required valid=0 work=11 ready=1 cnt=0 d1=0",
                  rsp_valid, work_2, req_ready, jobs_done, data_1_80);
      end
      Reset = 1'b0;
      exp_cnt = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         if (rsp_valid) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL reset_drop: rsp_valid cycles=%0d required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      for (int i = 0; i < 17; i++) begin
         send_req(2'(i % 4), {$urandom(), $urandom(), 14'($urandom())});
         // Competing request while busy must not be taken.
         req_valid = 1'b1;
         req_op    = 2'b00;
         req_data  = '1;
         wait_rsp(lat);
         req_valid = 1'b0;
         e = sb.pop_front();
         vectors++;
         if (lat != ((i % 4 == 3) ? 1 : 5) || rsp_op !== e.op || rsp_data !== e.data || rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL b2b_rsp job %0d: lat=%0d op=%b data=%h err=%b required op=%b data=%h err=%b",
                     i, lat, rsp_op, rsp_data, rsp_err, e.op, e.data, e.err);
         end
         @(negedge Clk);
         exp_cnt++;
         vectors++;
         if (jobs_done !== exp_cnt || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_cnt job %0d: cnt=%0d valid=%b required cnt=%0d valid=0", i, jobs_done, rsp_valid, exp_cnt);
         end
      end
      vectors++;
      if (jobs_done !== 4'd1 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_wrap: cnt=%0d pending=%0d required cnt=1 pending=0", jobs_done, sb.size());
      end
   endtask

   initial begin
      Reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      test_reset();
      test_encrypt();
      test_decrypt_pwgen();
      test_illegal();
      test_stall();
      test_reset_mid_wait();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
